adc_spi_reader: RTL and testbench

//  SPI master that reads the MAX19777-class ADC (3-wire: nCS, SCLK, DOUT) and presents each
//  12-bit conversion as a parallel word with a one-cycle valid strobe. Sits between the ADC pins
//  and the downstream sample path. Runs single frames or back-to-back frames while start is high.

---
 rtl/adc_spi_reader_pkg.sv | 18 +
 rtl/adc_spi_reader_half_tick.sv | 22 ++
 rtl/adc_spi_reader.sv | 96 +++++++++
 tb/tb_adc_spi_reader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_reader_pkg.sv
// Shared frame geometry and FSM encoding for the ADC SPI reader.
package adc_spi_reader_pkg;
  localparam int FRAME_BITS     = 16;
  localparam int DATA_BITS      = 12;
  localparam int DATA_FIRST_BIT = 2;
  localparam int DATA_LAST_BIT  = 13;
  // Bit 16 is high-Z and never stored, so the shift register keeps bits 1..15.
  localparam int SHREG_W        = FRAME_BITS - 1;
  // Bit k (1-based, rising-edge order) lands at shreg index FRAME_BITS-1-k.
  localparam int LEAD_IDX       = FRAME_BITS - 2;
  localparam int DATA_MSB_IDX   = FRAME_BITS - 1 - DATA_FIRST_BIT;
  localparam int TRAIL0_IDX     = FRAME_BITS - 2 - DATA_LAST_BIT;
  localparam int TRAIL1_IDX     = FRAME_BITS - 3 - DATA_LAST_BIT;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_LOW, ST_HIGH, ST_HOLD
  } state_t;
endpackage

// File: rtl/adc_spi_reader_half_tick.sv
// Half-period timebase: one-CLK tick every HALF_DIV cycles while enabled.
module adc_spi_reader_half_tick #(
  parameter int HALF_DIV = 2
) (
  input  logic CLK,
  input  logic nRST,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(HALF_DIV + 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == W'(HALF_DIV - 1));

  // Held at zero while disabled, so the first tick lands HALF_DIV cycles after enable.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)             cnt <= '0;
    else if (!en || tick)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/adc_spi_reader.sv
// SPI master for a 3-wire 12-bit ADC; one valid strobe per 16-clock frame.
module adc_spi_reader
  import adc_spi_reader_pkg::*;
#(
  parameter int HALF_DIV   = 2,
  parameter int CS_HIGH_HP = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 start,
  input  logic                 DOUT,
  output logic                 nCS,
  output logic                 SCLK,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int HW = $clog2(CS_HIGH_HP + 1);

  state_t             state;
  logic               tick;
  logic [4:0]         bit_cnt;
  logic [HW-1:0]      hold_cnt;
  logic [SHREG_W-1:0] shreg;

  adc_spi_reader_half_tick #(.HALF_DIV(HALF_DIV)) u_tick (
    .CLK  (CLK),
    .nRST (nRST),
    .en   (state != ST_IDLE),
    .tick (tick)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= ST_IDLE;
      nCS          <= 1'b1;
      SCLK         <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
      bit_cnt      <= '0;
      hold_cnt     <= '0;
      shreg        <= '0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          nCS   <= 1'b0;
          busy  <= 1'b1;
          state <= ST_SETUP;
        end
        ST_SETUP: if (tick) begin
          SCLK    <= 1'b0;
          bit_cnt <= '0;
          state   <= ST_LOW;
        end
        // DOUT has had a full low phase to settle; sample it as SCLK rises.
        ST_LOW: if (tick) begin
          SCLK    <= 1'b1;
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt != 5'(FRAME_BITS - 1)) shreg <= {shreg[SHREG_W-2:0], DOUT};
          state   <= ST_HIGH;
        end
        ST_HIGH: if (tick) begin
          if (bit_cnt < 5'(FRAME_BITS)) begin
            SCLK  <= 1'b0;
            state <= ST_LOW;
          end else begin
            nCS          <= 1'b1;
            sample       <= shreg[DATA_MSB_IDX -: DATA_BITS];
            frame_err    <= shreg[LEAD_IDX] | shreg[TRAIL0_IDX] | shreg[TRAIL1_IDX];
            sample_valid <= 1'b1;
            hold_cnt     <= '0;
            state        <= ST_HOLD;
          end
        end
        ST_HOLD: if (tick) begin
          if (hold_cnt == HW'(CS_HIGH_HP - 1)) begin
            if (start) begin
              nCS   <= 1'b0;
              state <= ST_SETUP;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench: two readers (HALF_DIV 1 and 3) each driven by a behavioural ADC.
module tb_adc_spi_reader;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        start, start3;
  logic        dout = 1'b0, dout3 = 1'b0;
  logic        ncs, sclk, valid, ferr, busy;
  logic        ncs3, sclk3, valid3, ferr3, busy3;
  logic [11:0] sample, sample3;

  int errs = 0, checks = 0;

  always #5 CLK = ~CLK;

  adc_spi_reader #(.HALF_DIV(1), .CS_HIGH_HP(2)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .DOUT(dout), .nCS(ncs), .SCLK(sclk),
    .sample(sample), .sample_valid(valid), .frame_err(ferr), .busy(busy));

  adc_spi_reader #(.HALF_DIV(3), .CS_HIGH_HP(2)) dut3 (
    .CLK(CLK), .nRST(nRST), .start(start3), .DOUT(dout3), .nCS(ncs3), .SCLK(sclk3),
    .sample(sample3), .sample_valid(valid3), .frame_err(ferr3), .busy(busy3));

  // ADC model: frame latched at nCS fall; bit k driven after the k-th SCLK fall.
  // Bit 16 is driven 1 to show it is ignored.
  logic [11:0] mw = 12'h000, mw3 = 12'h000;
  logic        auto_inc = 1'b0, f14 = 1'b0;
  int          base = 0, fcnt = 0;
  logic [15:0] fr, fr3;
  int          fi, fi3;

  always @(negedge ncs or negedge sclk) begin
    if (ncs === 1'b0) begin
      if (sclk) begin
        fr = {1'b0, (auto_inc ? mw + 12'(fcnt - base) : mw), f14, 1'b0, 1'b1};
        fi = 15;
        fcnt++;
      end else if (fi >= 0) begin
        dout = fr[fi];
        fi--;
      end
    end
  end

  always @(negedge ncs3 or negedge sclk3) begin
    if (ncs3 === 1'b0) begin
      if (sclk3) begin
        fr3 = {1'b0, mw3, 3'b001};
        fi3 = 15;
      end else if (fi3 >= 0) begin
        dout3 = fr3[fi3];
        fi3--;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Follows one frame of dut from its launch edge to the end of the following nCS-high run.
  task automatic run1(input int drop_at, output logic [11:0] s, output logic e,
                      output int lat, output int rises, output int hi);
    int   n;
    logic prev, got;
    n = 0; rises = 0; prev = sclk; got = 1'b0; s = '0; e = 1'b0; hi = 0;
    while (!got && n < 400) begin
      @(negedge CLK); n++;
      if (!prev && sclk) rises++;
      prev = sclk;
      if (rises >= drop_at) start = 1'b0;
      if (valid) begin got = 1'b1; s = sample; e = ferr; end
    end
    lat = n - 1;
    chk("valid_seen", got, 1'b1);
    hi = 1;
    @(negedge CLK);
    chk("valid_one_cycle", valid, 1'b0);
    while (ncs && busy && hi < 50) begin
      hi++;
      @(negedge CLK);
    end
  endtask

  logic [11:0] s;
  logic        e;
  int          lat, rises, hi, n, r, rise1, rise2, fall1, vcnt;
  logic        prev, got;

  initial begin
    nRST = 1'b0; start = 1'b0; start3 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_ncs", ncs, 1'b1);
    chk("rst_sclk", sclk, 1'b1);
    chk("rst_sample", sample, 12'h000);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ncs3", ncs3, 1'b1);
    nRST = 1'b1;
    @(negedge CLK);

    // single frame, one-cycle start
    mw = 12'hA5C;
    start = 1'b1;
    run1(0, s, e, lat, rises, hi);
    chk("t2_sample", s, 12'hA5C);
    chk("t2_ferr", e, 1'b0);
    chk("t2_latency", lat, 33);
    chk("t2_rises", rises, 16);
    chk("t2_cs_high", hi, 2);
    chk("t2_busy_low", busy, 1'b0);
    repeat (4) @(negedge CLK);
    chk("t2_stay_idle", ncs, 1'b1);

    // continuous: FFE, FFF, 000
    mw = 12'hFFE; auto_inc = 1'b1; base = fcnt;
    start = 1'b1;
    run1(99, s, e, lat, rises, hi);
    chk("t3_sample0", s, 12'hFFE);
    chk("t3_lat0", lat, 33);
    chk("t3_cs_high0", hi, 2);
    chk("t3_busy0", busy, 1'b1);
    run1(99, s, e, lat, rises, hi);
    chk("t3_sample1", s, 12'hFFF);
    chk("t3_cs_high1", hi, 2);
    chk("t3_rises1", rises, 16);
    run1(0, s, e, lat, rises, hi);
    chk("t3_sample2", s, 12'h000);
    chk("t3_ferr2", e, 1'b0);
    chk("t3_idle", busy, 1'b0);
    auto_inc = 1'b0;
    repeat (3) @(negedge CLK);

    // trailing-zero bit 14 forced high
    mw = 12'h3C7; f14 = 1'b1;
    start = 1'b1;
    run1(0, s, e, lat, rises, hi);
    chk("t4_ferr", e, 1'b1);
    chk("t4_sample", s, 12'h3C7);
    f14 = 1'b0;
    repeat (3) @(negedge CLK);

    // start dropped after rising edge 5
    mw = 12'h5A1;
    start = 1'b1;
    run1(5, s, e, lat, rises, hi);
    chk("t5_sample", s, 12'h5A1);
    chk("t5_latency", lat, 33);
    chk("t5_rises", rises, 16);
    repeat (5) @(negedge CLK);
    chk("t5_busy", busy, 1'b0);
    chk("t5_ncs", ncs, 1'b1);

    // reset after rising edge 8
    mw = 12'h0F0;
    start = 1'b1;
    n = 0; r = 0; prev = sclk;
    while (r < 8 && n < 200) begin
      @(negedge CLK); n++;
      start = 1'b0;
      if (!prev && sclk) r++;
      prev = sclk;
    end
    chk("t6_reach_rise8", r, 8);
    nRST = 1'b0;
    #1;
    chk("t6_ncs", ncs, 1'b1);
    chk("t6_sclk", sclk, 1'b1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_valid", valid, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    vcnt = 0;
    repeat (40) begin
      @(negedge CLK);
      if (valid) vcnt++;
    end
    chk("t6_no_valid", vcnt, 0);
    mw = 12'h9B4;
    start = 1'b1;
    run1(0, s, e, lat, rises, hi);
    chk("t6_sample", s, 12'h9B4);
    chk("t6_latency", lat, 33);

    // HALF_DIV=3 timing
    mw3 = 12'h6D2;
    start3 = 1'b1;
    n = 0; r = 0; rise1 = 0; rise2 = 0; fall1 = 0; prev = sclk3; got = 1'b0; s = '0;
    while (!got && n < 400) begin
      @(negedge CLK); n++;
      start3 = 1'b0;
      if (!prev && sclk3) begin
        r++;
        if (r == 1) rise1 = n;
        if (r == 2) rise2 = n;
      end
      if (prev && !sclk3 && r == 1) fall1 = n;
      prev = sclk3;
      if (valid3) begin got = 1'b1; s = sample3; end
    end
    chk("t7_valid_seen", got, 1'b1);
    chk("t7_latency", n - 1, 99);
    chk("t7_rises", r, 16);
    chk("t7_period", rise2 - rise1, 6);
    chk("t7_high_time", fall1 - rise1, 3);
    chk("t7_sample", s, 12'h6D2);
    chk("t7_ferr", ferr3, 1'b0);
    repeat (10) @(negedge CLK);
    chk("t7_busy", busy3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
